therm_to_bin_pipe: RTL

//  Pipelined thermometer-to-binary encoder. It is the stage downstream of the 8-bit

---
 rtl/therm_pkg.sv | 16 +
 rtl/therm_group_enc.sv | 27 ++
 rtl/therm_to_bin_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/therm_pkg.sv
// Shared types and default sizes for the pipelined thermometer-to-binary encoder.
package therm_pkg;

  localparam int unsigned THERM_W = 256;
  localparam int unsigned GROUP_W = 16;
  localparam int unsigned NGROUPS = THERM_W / GROUP_W;
  localparam int unsigned HI_W    = $clog2(GROUP_W);

  typedef struct packed {
    logic            any;
    logic            all;
    logic            ok;
    logic [HI_W-1:0] hi;
  } group_info_t;

endpackage

// File: rtl/therm_group_enc.sv
// Combinational summary of one GROUP_W-bit slice of the thermometer code.
module therm_group_enc
  import therm_pkg::*;
(
  input  logic [GROUP_W-1:0] grp_i,
  output group_info_t        info_o
);

  logic [GROUP_W-1:0] grp_inc;
  logic [HI_W-1:0]    hi;

  assign grp_inc = grp_i + {{(GROUP_W-1){1'b0}}, 1'b1};

  always_comb begin
    hi = '0;
    for (int unsigned i = 0; i < GROUP_W; i++) begin
      if (grp_i[i]) hi = i[HI_W-1:0];
    end
  end

  // Contiguous ones from bit 0 (incl. all-zero and all-one) make grp+1 a power of two or zero.
  assign info_o.any = |grp_i;
  assign info_o.all = &grp_i;
  assign info_o.ok  = ~|(grp_i & grp_inc);
  assign info_o.hi  = hi;

endmodule

// File: rtl/therm_to_bin_pipe.sv
// Two-stage valid/ready thermometer-to-binary encoder with illegal-code flag and
// saturating error counter. GROUP_W must match therm_pkg::GROUP_W (struct field width).
module therm_to_bin_pipe
  import therm_pkg::*;
#(
  parameter int unsigned THERM_W = therm_pkg::THERM_W,
  parameter int unsigned GROUP_W = therm_pkg::GROUP_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [THERM_W-1:0]         therm_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(THERM_W)-1:0] bin_out,
  output logic                       bin_err,
  output logic [CNT_W-1:0]           err_cnt,
  input  logic                       err_clr
);

  localparam int unsigned BIN_W  = $clog2(THERM_W);
  localparam int unsigned NG     = THERM_W / GROUP_W;
  localparam int unsigned GSEL_W = $clog2(NG);

  group_info_t [NG-1:0] grp_info;
  group_info_t [NG-1:0] s1_info_q, s1_info_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [BIN_W-1:0]     s2_bin_q, s2_bin_d;
  logic                 s2_err_q, s2_err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 s1_adv, s2_adv;
  logic                 any_all, lower_all;
  logic [GSEL_W-1:0]    gsel;
  logic [BIN_W-1:0]     sel_bin;
  logic                 sel_err;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    therm_group_enc u_enc (
      .grp_i  (therm_in[g*GROUP_W +: GROUP_W]),
      .info_o (grp_info[g])
    );
  end

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // MSB-priority group select; groups below the winner must be solid ones.
  always_comb begin
    any_all   = 1'b0;
    gsel      = '0;
    lower_all = 1'b1;
    for (int unsigned g = 0; g < NG; g++) begin
      if (s1_info_q[g].any) begin
        any_all = 1'b1;
        gsel    = g[GSEL_W-1:0];
      end
    end
    for (int unsigned g = 0; g < NG; g++) begin
      if (g < 32'(gsel) && !s1_info_q[g].all) lower_all = 1'b0;
    end
    sel_bin = {gsel, s1_info_q[gsel].hi};
    sel_err = !any_all || !s1_info_q[gsel].ok || !lower_all;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_info_d  = s1_info_q;
    s2_valid_d = s2_valid_q;
    s2_bin_d   = s2_bin_q;
    s2_err_d   = s2_err_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_info_d = grp_info;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_bin_d = sel_bin;
        s2_err_d = sel_err;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end else if (s2_valid_q && out_ready && s2_err_q && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_info_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_bin_q   <= '0;
      s2_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_info_q  <= s1_info_d;
      s2_valid_q <= s2_valid_d;
      s2_bin_q   <= s2_bin_d;
      s2_err_q   <= s2_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign bin_out   = s2_bin_q;
  assign bin_err   = s2_err_q;
  assign err_cnt   = cnt_q;

endmodule
